router_pkt_rx: RTL and testbench
================================

ROUTER_PKT_RX -- requirements
Module: router_pkt_rx

Interface
REQ-001 SHALL have parameter PORT_ID, default 2'd0: router output port this instance drains; header address mismatch is an error.
REQ-002 SHALL have parameter STALL_MAX, default 29: maximum cycles vld_out may stay high unread, below the router's 30-cycle FIFO soft-reset window.
REQ-003 SHALL have port clock  in  1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port vld_out  in  1: router output FIFO non-empty.
REQ-006 SHALL have port data_out  in  8: router FIFO read data, valid the cycle after read_enb is sampled high.
REQ-007 SHALL have port read_enb  out  1: FIFO read request.
REQ-008 SHALL have port rx_ready  in  1: downstream sink can accept a byte.
REQ-009 SHALL have port rd_data  out  8: forwarded packet byte.
REQ-010 SHALL have port rd_valid  out  1: rd_data valid, one-cycle qualifier.
REQ-011 SHALL have port rd_sop / rd_eop  out  1 each: header byte / parity byte marker.
REQ-012 SHALL have port pkt_done  out  1: one-cycle pulse at packet end.
REQ-013 SHALL have port pkt_err  out  1: one-cycle pulse with pkt_done when the packet is bad.
REQ-014 SHALL have port err_code  out  2: 00 none, 01 parity, 10 address, 11 aborted; held until the next pkt_done.
REQ-015 SHALL have port stall  out  1: vld_out high with no read for STALL_MAX cycles.

Function
REQ-016 SHALL implement an FSM with states IDLE, HDR_WAIT, BODY, DONE.
REQ-017 IDLE: read_enb = vld_out & rx_ready; on a read -> HDR_WAIT.
REQ-018 HDR_WAIT: read_enb low; the header byte arrives; SHALL latch len = data[7:2] and addr = data[1:0], load remaining = len+1 (7-bit), and seed parity = header; -> BODY.
REQ-019 BODY: read_enb = vld_out & rx_ready & (issued < len+1); each arriving byte decrements remaining; payload bytes XOR into parity.
REQ-020 The byte arriving with remaining==1 is the parity byte: rd_eop=1, compared with the accumulated parity; -> DONE.
REQ-021 DONE: one cycle; pkt_done=1; pkt_err=1 if any error; -> IDLE; read_enb low.
REQ-022 Every received byte SHALL appear on rd_data with rd_valid exactly one cycle after its read_enb; rd_sop on the header only.
REQ-023 len=0 SHALL be legal: header then parity only; parity must equal the header.
REQ-024 Error priority SHALL be address > parity; an address mismatch still drains the full packet.
REQ-025 If vld_out falls in BODY with remaining>0 and stays low 2 consecutive cycles (router soft reset), SHALL go to DONE with err_code 11.
REQ-026 The stall counter SHALL count cycles with vld_out=1 & read_enb=0, clear on a read or vld_out=0, and saturate at STALL_MAX; stall = (count==STALL_MAX).
REQ-027 Back-to-back packets SHALL be supported: IDLE may issue a read in the cycle after DONE.

Reset
REQ-028 On reset: state IDLE, read_enb=0, rd_valid=0, rd_sop=0, rd_eop=0, pkt_done=0, pkt_err=0, err_code=00, stall=0, counters=0; an in-flight read is discarded.

Configuration
REQ-029 With ROUTER_PKT_RX_STATS_EN defined, SHALL add outputs pkt_cnt[15:0] and err_cnt[15:0], saturating at 16'hFFFF, incremented on pkt_done / pkt_err and cleared by reset.
REQ-030 Without ROUTER_PKT_RX_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-031 The shared package router_pkg SHALL hold the FSM state enum, the err_code constants, and the header field positions (ADDR_LSB=0, LEN_LSB=2, LEN_W=6).
REQ-032 SHALL contain one sub-module, router_parity_chk: running XOR accumulator with clear, seed, and compare.

Verification
REQ-033 Header 8'h0C (len 3, addr 0), payload 11,22,33, parity 0C^11^22^33 -> 5 rd_valid beats, sop on the first, eop on the last, pkt_done=1, pkt_err=0.
REQ-034 Same packet with the parity byte flipped -> pkt_err=1, err_code=01.
REQ-035 PORT_ID=1, header 8'h04 -> full drain, err_code=10.
REQ-036 rx_ready held low 40 cycles while vld_out=1 -> stall=1 at cycle 29; no read_enb is issued.
REQ-037 vld_out dropped for 2 cycles after 2 of 5 bytes -> pkt_done with err_code=11; the next packet is received cleanly.
REQ-038 len=0 packet (8'h00, 8'h00) followed immediately by another packet -> two pkt_done pulses, both without error; with STATS_EN, pkt_cnt=2.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router packet receiver
package router_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HDR_WAIT = 2'd1,
      BODY     = 2'd2,
      DONE     = 2'd3
   } state_e;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_PARITY = 2'b01;
   localparam logic [1:0] ERR_ADDR   = 2'b10;
   localparam logic [1:0] ERR_ABORT  = 2'b11;

   localparam int ADDR_LSB = 0;
   localparam int ADDR_W   = 2;
   localparam int LEN_LSB  = 2;
   localparam int LEN_W    = 6;

endpackage

// File: rtl/router_parity_chk.sv
// rtl/router_parity_chk.sv - running XOR parity accumulator with clear, seed and compare
module router_parity_chk
   import router_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clr,
   input  logic       seed,
   input  logic [7:0] seed_data,
   input  logic       acc_en,
   input  logic [7:0] acc_data,
   input  logic [7:0] cmp_data,
   output logic       match
);

   logic [7:0] par_q;
   logic [7:0] par_d;

   always_comb begin
      par_d = par_q;
      if (clr) begin
         par_d = 8'h00;
      end else if (seed) begin
         par_d = seed_data;
      end else if (acc_en) begin
         par_d = par_q ^ acc_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         par_q <= 8'h00;
      end else begin
         par_q <= par_d;
      end
   end

   assign match = (par_q == cmp_data);

endmodule

// File: rtl/router_pkt_rx.sv
// rtl/router_pkt_rx.sv - drains one router output FIFO and checks packets; ROUTER_PKT_RX_STATS_EN adds counters
module router_pkt_rx
   import router_pkg::*;
#(
   parameter logic [1:0] PORT_ID   = 2'd0,
   parameter int         STALL_MAX = 29
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       vld_out,
   input  logic [7:0] data_out,
   output logic       read_enb,
   input  logic       rx_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       rd_sop,
   output logic       rd_eop,
   output logic       pkt_done,
   output logic       pkt_err,
   output logic [1:0] err_code,
   output logic       stall
`ifdef ROUTER_PKT_RX_STATS_EN
   ,
   output logic [15:0] pkt_cnt,
   output logic [15:0] err_cnt
`endif
);

   localparam int SW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
   localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [6:0]       rem_q, rem_d;
   logic [6:0]       issued_q, issued_d;
   logic             addr_err_q, addr_err_d;
   logic             par_err_q, par_err_d;
   logic             abort_q, abort_d;
   logic             vld_low_q, vld_low_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_sop_q, rd_sop_d;
   logic             rd_eop_q, rd_eop_d;
   logic             pkt_done_q, pkt_done_d;
   logic             pkt_err_q, pkt_err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic [SW-1:0]    stall_cnt_q, stall_cnt_d;

   logic [6:0]       len_p1;
   logic             par_clr, par_seed, par_acc, par_match;

   assign len_p1 = {1'b0, len_q} + 7'd1;

   always_comb begin
      read_enb = 1'b0;
      case (state_q)
         IDLE:    read_enb = vld_out & rx_ready;
         BODY:    read_enb = vld_out & rx_ready & (issued_q < len_p1);
         default: read_enb = 1'b0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      rem_d       = rem_q;
      issued_d    = issued_q;
      addr_err_d  = addr_err_q;
      par_err_d   = par_err_q;
      abort_d     = abort_q;
      vld_low_d   = 1'b0;
      rd_valid_d  = read_enb;
      rd_sop_d    = 1'b0;
      rd_eop_d    = 1'b0;
      pkt_done_d  = 1'b0;
      pkt_err_d   = 1'b0;
      err_code_d  = err_code_q;
      par_clr     = 1'b0;
      par_seed    = 1'b0;
      par_acc     = 1'b0;

      case (state_q)
         IDLE: begin
            issued_d = 7'd0;
            if (read_enb) begin
               rd_sop_d = 1'b1;
               state_d  = HDR_WAIT;
            end
         end
         HDR_WAIT: begin
            // The header read was issued from IDLE, so its byte is on data_out now.
            len_d      = data_out[LEN_LSB +: LEN_W];
            addr_err_d = (data_out[ADDR_LSB +: ADDR_W] != PORT_ID);
            rem_d      = {1'b0, data_out[LEN_LSB +: LEN_W]} + 7'd1;
            issued_d   = 7'd0;
            par_err_d  = 1'b0;
            abort_d    = 1'b0;
            par_seed   = 1'b1;
            state_d    = BODY;
         end
         BODY: begin
            vld_low_d = ~vld_out;
            if (read_enb) begin
               issued_d = issued_q + 7'd1;
               rd_eop_d = (issued_q == {1'b0, len_q});
            end
            if (rd_valid_q) begin
               rem_d = rem_q - 7'd1;
               if (rem_q == 7'd1) begin
                  par_err_d = ~par_match;
                  state_d   = DONE;
               end else begin
                  par_acc = 1'b1;
               end
            end else if (!vld_out && vld_low_q) begin
               // Two idle cycles mid-packet means the router flushed its FIFO.
               abort_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            par_clr = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_d == DONE && state_q != DONE) begin
         pkt_done_d = 1'b1;
         if (abort_d)         err_code_d = ERR_ABORT;
         else if (addr_err_d) err_code_d = ERR_ADDR;
         else if (par_err_d)  err_code_d = ERR_PARITY;
         else                 err_code_d = ERR_NONE;
         pkt_err_d = (err_code_d != ERR_NONE);
      end

      stall_cnt_d = stall_cnt_q;
      if (vld_out && !read_enb) begin
         if (stall_cnt_q != STALL_LIM) stall_cnt_d = stall_cnt_q + 1'b1;
      end else begin
         stall_cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         rem_q       <= 7'd0;
         issued_q    <= 7'd0;
         addr_err_q  <= 1'b0;
         par_err_q   <= 1'b0;
         abort_q     <= 1'b0;
         vld_low_q   <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_sop_q    <= 1'b0;
         rd_eop_q    <= 1'b0;
         pkt_done_q  <= 1'b0;
         pkt_err_q   <= 1'b0;
         err_code_q  <= ERR_NONE;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         issued_q    <= issued_d;
         addr_err_q  <= addr_err_d;
         par_err_q   <= par_err_d;
         abort_q     <= abort_d;
         vld_low_q   <= vld_low_d;
         rd_valid_q  <= rd_valid_d;
         rd_sop_q    <= rd_sop_d;
         rd_eop_q    <= rd_eop_d;
         pkt_done_q  <= pkt_done_d;
         pkt_err_q   <= pkt_err_d;
         err_code_q  <= err_code_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   router_parity_chk u_parity (
      .clock     (clock),
      .reset     (reset),
      .clr       (par_clr),
      .seed      (par_seed),
      .seed_data (data_out),
      .acc_en    (par_acc),
      .acc_data  (data_out),
      .cmp_data  (data_out),
      .match     (par_match)
   );

   assign rd_data  = data_out;
   assign rd_valid = rd_valid_q;
   assign rd_sop   = rd_sop_q;
   assign rd_eop   = rd_eop_q;
   assign pkt_done = pkt_done_q;
   assign pkt_err  = pkt_err_q;
   assign err_code = err_code_q;
   assign stall    = (stall_cnt_q == STALL_LIM);

`ifdef ROUTER_PKT_RX_STATS_EN
   logic [15:0] pkt_cnt_q, pkt_cnt_d;
   logic [15:0] err_cnt_q, err_cnt_d;

   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      err_cnt_d = err_cnt_q;
      if (pkt_done_q && pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      if (pkt_err_q && err_cnt_q != 16'hFFFF)  err_cnt_d = err_cnt_q + 16'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pkt_cnt_q <= 16'd0;
         err_cnt_q <= 16'd0;
      end else begin
         pkt_cnt_q <= pkt_cnt_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign pkt_cnt = pkt_cnt_q;
   assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_router_pkt_rx.sv
// tb/tb_router_pkt_rx.sv - scoreboard bench for router_pkt_rx with a router FIFO model
module tb_router_pkt_rx;

   typedef struct packed {
      logic [7:0] d;
      logic       sop;
      logic       eop;
   } beat_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       vld_out = 1'b0;
   logic [7:0] data_out = 8'h00;
   logic       rx_ready = 1'b1;
   logic       read_enb;
   logic [7:0] rd_data;
   logic       rd_valid, rd_sop, rd_eop, pkt_done, pkt_err, stall;
   logic [1:0] err_code;
`ifdef ROUTER_PKT_RX_STATS_EN
   logic [15:0] pkt_cnt, err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo[$];
   beat_t      exp_beats[$];
   logic [1:0] exp_codes[$];

   router_pkt_rx dut (
      .clock    (clock),
      .reset    (reset),
      .vld_out  (vld_out),
      .data_out (data_out),
      .read_enb (read_enb),
      .rx_ready (rx_ready),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_sop   (rd_sop),
      .rd_eop   (rd_eop),
      .pkt_done (pkt_done),
      .pkt_err  (pkt_err),
      .err_code (err_code),
      .stall    (stall)
`ifdef ROUTER_PKT_RX_STATS_EN
      ,
      .pkt_cnt  (pkt_cnt),
      .err_cnt  (err_cnt)
`endif
   );

   always #5 clock = ~clock;

   // Router output FIFO: read data valid the cycle after read_enb is sampled.
   always @(posedge clock) begin
      if (read_enb && fifo.size() > 0) data_out <= fifo.pop_front();
      vld_out <= (fifo.size() > 0);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp_v);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (rd_valid) begin
            if (exp_beats.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat act=%0h exp=none", rd_data);
            end else begin
               beat_t b;
               b = exp_beats.pop_front();
               chk("beat_data", {24'd0, rd_data}, {24'd0, b.d});
               chk("beat_sop", {31'd0, rd_sop}, {31'd0, b.sop});
               chk("beat_eop", {31'd0, rd_eop}, {31'd0, b.eop});
            end
         end
         if (pkt_done) begin
            if (exp_codes.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done act=%0h exp=none", err_code);
            end else begin
               logic [1:0] c;
               c = exp_codes.pop_front();
               chk("err_code", {30'd0, err_code}, {30'd0, c});
               chk("pkt_err", {31'd0, pkt_err}, {31'd0, (c != 2'b00)});
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b, input logic sop, input logic eop);
      fifo.push_back(b);
      exp_beats.push_back('{d: b, sop: sop, eop: eop});
   endtask

   // Payload bytes are 11,22,33,... ; parity and code are hand-computed by the caller.
   task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par,
                           input logic [1:0] code);
      logic [7:0] b;
      b = 8'h00;
      push_byte(hdr, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
         b = b + 8'h11;
         push_byte(b, 1'b0, 1'b0);
      end
      push_byte(par, 1'b0, 1'b1);
      exp_codes.push_back(code);
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while ((exp_beats.size() != 0 || exp_codes.size() != 0) && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk(nm, exp_beats.size() + exp_codes.size(), 0);
      exp_beats.delete();
      exp_codes.delete();
      fifo.delete();
      repeat (3) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1);
   end

   initial begin
      bit seen_read;
      int n;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("rst_read_enb", {31'd0, read_enb}, 0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 0);
      chk("rst_sop_eop", {30'd0, rd_sop, rd_eop}, 0);
      chk("rst_pkt_done", {31'd0, pkt_done}, 0);
      chk("rst_pkt_err", {31'd0, pkt_err}, 0);
      chk("rst_err_code", {30'd0, err_code}, 0);
      chk("rst_stall", {31'd0, stall}, 0);

      send_pkt(8'h0C, 3, 8'h0C, 2'b00);
      wait_drain("drain_good");

      send_pkt(8'h0C, 3, 8'hF3, 2'b01);
      wait_drain("drain_badpar");
      chk("err_code_held", {30'd0, err_code}, 2'b01);

      send_pkt(8'h05, 1, 8'h14, 2'b10);
      wait_drain("drain_addr");

      send_pkt(8'h09, 2, 8'h00, 2'b10);
      wait_drain("drain_addr_over_par");

      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      send_pkt(8'h00, 0, 8'h00, 2'b00);
      send_pkt(8'h08, 2, 8'h3B, 2'b00);
      wait_drain("drain_b2b");
`ifdef ROUTER_PKT_RX_STATS_EN
      chk("pkt_cnt", {16'd0, pkt_cnt}, 2);
      chk("err_cnt", {16'd0, err_cnt}, 0);
`endif

      push_byte(8'h0C, 1'b1, 1'b0);
      push_byte(8'h11, 1'b0, 1'b0);
      exp_codes.push_back(2'b11);
      wait_drain("drain_abort");
      send_pkt(8'h0C, 3, 8'h0C, 2'b00);
      wait_drain("drain_after_abort");

      rx_ready = 1'b0;
      send_pkt(8'h0C, 3, 8'h0C, 2'b00);
      n = 0;
      while (!vld_out && n < 10) begin
         @(negedge clock);
         n++;
      end
      chk("stall_vld_seen", {31'd0, vld_out}, 1);
      seen_read = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clock);
         if (read_enb) seen_read = 1'b1;
         if (i == 28) chk("stall_at_28", {31'd0, stall}, 0);
         if (i == 29) chk("stall_at_29", {31'd0, stall}, 1);
         if (i == 40) chk("stall_at_40", {31'd0, stall}, 1);
      end
      chk("no_read_not_ready", {31'd0, seen_read}, 0);
      rx_ready = 1'b1;
      wait_drain("drain_stall");
      chk("stall_cleared", {31'd0, stall}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
